// File: rtl/tetris_pkg.sv
// Shared types and constants for the line clear engine: FSM state
// encoding, line-count width and score weights for 1/2/3/4+ lines.
package tetris_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } lce_state_t;

    localparam int LINES_W = 6;
    localparam int SCORE_W = 20;

    localparam logic [SCORE_W-1:0] SCORE_1 = 20'd40;
    localparam logic [SCORE_W-1:0] SCORE_2 = 20'd100;
    localparam logic [SCORE_W-1:0] SCORE_3 = 20'd300;
    localparam logic [SCORE_W-1:0] SCORE_4 = 20'd1200;

endpackage

// File: rtl/line_clear_engine_score_accum.sv
// score_accum: turns the number of lines removed in a pass into points
// and adds them to a saturating score register. Only built when the
// SCORE_LINES_EN macro is defined in the top level.
module score_accum
    import tetris_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               add_en,
    input  logic [LINES_W-1:0] lines,
    output logic [SCORE_W-1:0] score
);

    logic [SCORE_W-1:0] weight_s;
    logic [SCORE_W:0]   sum_s;
    logic [SCORE_W-1:0] score_r;

    // Points awarded for a single pass; four or more lines pay the top weight
    always_comb begin
        weight_s = '0;
        case (lines)
            6'd0:    weight_s = '0;
            6'd1:    weight_s = SCORE_1;
            6'd2:    weight_s = SCORE_2;
            6'd3:    weight_s = SCORE_3;
            default: weight_s = SCORE_4;
        endcase
    end

    // One extra bit exposes overflow so the register can clamp
    always_comb begin
        sum_s = {1'b0, score_r} + {1'b0, weight_s};
    end

    // Accumulator, clamped at all ones
    always_ff @(posedge clk) begin
        if (reset) begin
            score_r <= '0;
        end else if (add_en) begin
            score_r <= sum_s[SCORE_W] ? {SCORE_W{1'b1}} : sum_s[SCORE_W-1:0];
        end
    end

    assign score = score_r;

endmodule

// File: rtl/line_clear_engine.sv
// line_clear_engine: register-based playfield occupancy with piece
// locking, a row-by-row clear pass (bottom to top) that collapses full
// rows, a registered render read port and a spawn-area game-over flag.
// Optional: define SCORE_LINES_EN to add the score port and accumulator.
module line_clear_engine
    import tetris_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int HEIGHT     = 20,
    parameter int SPAWN_ROWS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       lock_valid,
    input  logic [$clog2(HEIGHT)-1:0]  lock_row,
    input  logic [WIDTH-1:0]           lock_mask,
    output logic                       lock_ready,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [LINES_W-1:0]         lines_cleared,
    input  logic [$clog2(HEIGHT)-1:0]  rd_row,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       game_over
`ifdef SCORE_LINES_EN
    ,
    output logic [SCORE_W-1:0]         score
`endif
);

    localparam int ROW_W = $clog2(HEIGHT);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    logic [WIDTH-1:0]   board_r [HEIGHT];
    lce_state_t         state_r, state_s;
    logic [ROW_W-1:0]   ptr_r, ptr_s;
    logic [LINES_W-1:0] cnt_r, cnt_s;
    logic               busy_r;
    logic               done_r;
    logic [LINES_W-1:0] lines_cleared_r;
    logic [WIDTH-1:0]   rd_data_r;
    logic               game_over_r;
    logic               row_full_s;
    logic               lock_fire_s;
    logic               spawn_any_s;

    // A lock lands only while idle and only for rows that exist
    always_comb begin
        lock_fire_s = lock_valid && !busy_r && (int'(lock_row) < HEIGHT);
        row_full_s  = &board_r[ptr_r];
    end

    // Next-state logic for the clear pass
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_SCAN;
                    ptr_s   = LAST_ROW;
                    cnt_s   = '0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SCAN: begin
                if (row_full_s) begin
                    state_s = S_SHIFT;
                end else if (ptr_r == '0) begin
                    state_s = S_DONE;
                end else begin
                    ptr_s = ptr_r - ROW_W'(1);
                end
            end
            S_SHIFT: begin
                // Pointer stays put: the row that fell into place is rescanned
                state_s = S_SCAN;
                cnt_s   = (cnt_r == 6'd63) ? cnt_r : cnt_r + 6'd1;
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM registers; status outputs are derived from the next state so they
    // are registered yet line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= S_IDLE;
            ptr_r           <= LAST_ROW;
            cnt_r           <= '0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            lines_cleared_r <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != S_IDLE);
            done_r  <= (state_s == S_DONE);
            if (state_s == S_DONE) begin
                lines_cleared_r <= cnt_s;
            end
        end
    end

    // Playfield storage: collapse on SHIFT, otherwise OR in accepted locks
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < HEIGHT; k++) begin
                board_r[k] <= '0;
            end
        end else if (state_r == S_SHIFT) begin
            board_r[0] <= '0;
            for (int k = 1; k < HEIGHT; k++) begin
                if (k <= int'(ptr_r)) begin
                    board_r[k] <= board_r[k-1];
                end
            end
        end else if (lock_fire_s) begin
            board_r[lock_row] <= board_r[lock_row] | lock_mask;
        end
    end

    // Any occupied cell in the spawn rows ends the game
    always_comb begin
        spawn_any_s = 1'b0;
        for (int k = 0; k < SPAWN_ROWS; k++) begin
            spawn_any_s = spawn_any_s | (|board_r[k]);
        end
    end

    // Render read port and game-over flag, both one cycle behind the board
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r   <= '0;
            game_over_r <= 1'b0;
        end else begin
            rd_data_r   <= (int'(rd_row) < HEIGHT) ? board_r[rd_row] : '0;
            game_over_r <= spawn_any_s;
        end
    end

`ifdef SCORE_LINES_EN
    score_accum u_score_accum (
        .clk    (clk),
        .reset  (reset),
        .add_en (state_s == S_DONE),
        .lines  (cnt_s),
        .score  (score)
    );
`endif

    assign lock_ready    = ~busy_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign lines_cleared = lines_cleared_r;
    assign rd_data       = rd_data_r;
    assign game_over     = game_over_r;

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine (WIDTH=10, HEIGHT=20,
// SPAWN_ROWS=2). The driver updates a queue-based board model and pushes
// expected results; the monitor compares on done pulses and on due cycles.
module tb_line_clear_engine;

    localparam int W  = 10;
    localparam int H  = 20;
    localparam int SP = 2;
    localparam int RW = $clog2(H);
    localparam logic [W-1:0] FULL = {W{1'b1}};

    localparam int K_RD = 0;
    localparam int K_GO = 1;
    localparam int K_LC = 2;
    localparam int K_SC = 3;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          lock_valid;
    logic [RW-1:0] lock_row;
    logic [W-1:0]  lock_mask;
    logic          lock_ready;
    logic          start;
    logic          busy;
    logic          done;
    logic [5:0]    lines_cleared;
    logic [RW-1:0] rd_row;
    logic [W-1:0]  rd_data;
    logic          game_over;
    logic [19:0]   score;

    line_clear_engine #(.WIDTH(W), .HEIGHT(H), .SPAWN_ROWS(SP)) dut (
        .clk           (CLOCK_50),
        .reset         (reset),
        .lock_valid    (lock_valid),
        .lock_row      (lock_row),
        .lock_mask     (lock_mask),
        .lock_ready    (lock_ready),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .rd_row        (rd_row),
        .rd_data       (rd_data),
        .game_over     (game_over)
`ifdef SCORE_LINES_EN
        ,
        .score         (score)
`endif
    );

`ifndef SCORE_LINES_EN
    assign score = 20'd0;
`endif

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct { int cyc; int lines; int score; } done_t;
    typedef struct { int cyc; int kind; int exp; } chk_t;
    done_t done_q[$];
    chk_t  chk_q[$];

    int tests  = 0;
    int failed = 0;
    int busy_from = 1;
    int busy_to   = 0;

    logic [W-1:0] mb [H];
    int m_score = 0;

    // Remove full rows; survivors keep their order and settle at the bottom
    function automatic int model_pass();
        logic [W-1:0] keep [$];
        int n = 0;
        for (int k = H - 1; k >= 0; k--) begin
            if (mb[k] == FULL) n++;
            else keep.push_back(mb[k]);
        end
        for (int k = H - 1; k >= 0; k--) begin
            if (keep.size() > 0) mb[k] = keep.pop_front();
            else mb[k] = '0;
        end
        return n;
    endfunction

    function automatic int points(input int n);
        if (n == 0) return 0;
        if (n == 1) return 40;
        if (n == 2) return 100;
        if (n == 3) return 300;
        return 1200;
    endfunction

    function automatic int spawn_occupied();
        int g = 0;
        for (int k = 0; k < SP; k++) if (mb[k] != '0) g = 1;
        return g;
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_chk(input int at, input int kind, input int exp);
        chk_t c;
        c.cyc = at; c.kind = kind; c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic do_lock(input int row, input logic [W-1:0] mask);
        lock_valid = 1'b1;
        lock_row   = RW'(row);
        lock_mask  = mask;
        if (row < H) mb[row] = mb[row] | mask;
        tick();
        lock_valid = 1'b0;
        push_chk(cyc + 1, K_GO, spawn_occupied());
    endtask

    task automatic start_pass(input bit with_lock, input int row, input logic [W-1:0] mask);
        done_t d;
        int n;
        int t;
        t = cyc;
        start = 1'b1;
        if (with_lock) begin
            lock_valid = 1'b1;
            lock_row   = RW'(row);
            lock_mask  = mask;
            if (row < H) mb[row] = mb[row] | mask;
        end
        n = model_pass();
        m_score = m_score + points(n);
        if (m_score > 20'hFFFFF) m_score = 20'hFFFFF;
        d.cyc = t + H + 2 * n + 1; d.lines = n; d.score = m_score;
        done_q.push_back(d);
        busy_from = t + 1;
        busy_to   = t + H + 2 * n + 1;
        tick();
        start      = 1'b0;
        lock_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_q.size() != 0 && guard < 300) begin
            tick();
            guard++;
        end
        push_chk(cyc, K_LC, done_q.size() == 0 ? int'(lines_cleared_exp()) : -1);
        push_chk(cyc, K_GO, spawn_occupied());
    endtask

    int last_lines = 0;
    function automatic int lines_cleared_exp();
        return last_lines;
    endfunction

    task automatic read_all();
        for (int r = 0; r < H; r++) begin
            rd_row = RW'(r);
            push_chk(cyc + 1, K_RD, int'(mb[r]));
            tick();
        end
        rd_row = RW'($urandom_range(H, (1 << RW) - 1));
        push_chk(cyc + 1, K_RD, 0);
        tick();
        tick();
    endtask

    // Monitor: per-cycle busy/ready, done scoreboard, and due-cycle checks
    always @(negedge CLOCK_50) begin : mon
        done_t d;
        chk_t  c;
        int    act;
        bit    eb;
        eb = (cyc >= busy_from) && (cyc <= busy_to);
        tests++;
        if (busy !== eb) begin
            failed++;
            $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, eb);
        end
        tests++;
        if (lock_ready !== !eb) begin
            failed++;
            $display("FAIL lock_ready cyc=%0d got %b want %b", cyc, lock_ready, !eb);
        end
        if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
            d = done_q.pop_front();
            tests++;
            failed++;
            $display("FAIL done_missing cyc=%0d got none want pulse at %0d", cyc, d.cyc);
        end
        if (done === 1'b1) begin
            tests++;
            if (done_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_done cyc=%0d got pulse want none", cyc);
            end else begin
                d = done_q.pop_front();
                last_lines = d.lines;
                if (cyc != d.cyc) begin
                    failed++;
                    $display("FAIL done_cycle got %0d want %0d", cyc, d.cyc);
                end
                tests++;
                if (int'(lines_cleared) != d.lines) begin
                    failed++;
                    $display("FAIL lines_at_done got %0d want %0d", lines_cleared, d.lines);
                end
`ifdef SCORE_LINES_EN
                tests++;
                if (int'(score) != d.score) begin
                    failed++;
                    $display("FAIL score got %0d want %0d", score, d.score);
                end
`endif
            end
        end
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c = chk_q.pop_front();
            case (c.kind)
                K_RD:    act = int'(rd_data);
                K_GO:    act = int'(game_over);
                K_LC:    act = int'(lines_cleared);
                default: act = int'(score);
            endcase
            tests++;
            if (act != c.exp) begin
                failed++;
                $display("FAIL check_kind%0d cyc=%0d got %0h want %0h", c.kind, cyc, act, c.exp);
            end
        end
    end

    initial begin
        reset = 1'b1; lock_valid = 1'b0; lock_row = '0; lock_mask = '0;
        start = 1'b0; rd_row = '0;
        for (int k = 0; k < H; k++) mb[k] = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        push_chk(cyc, K_GO, 0);
        push_chk(cyc, K_LC, 0);
        push_chk(cyc, K_SC, 0);
        read_all();

        // Single bottom line
        do_lock(19, FULL);
        start_pass(1'b0, 0, '0);
        wait_done();
        read_all();

        // Four lines with a partial row above
        for (int r = 16; r < 20; r++) do_lock(r, FULL);
        do_lock(15, 10'h001);
        start_pass(1'b0, 0, '0);
        wait_done();
        read_all();

        // Interleaved full and partial rows (row 19 already holds 0x001)
        do_lock(17, FULL);
        do_lock(18, 10'h155);
        do_lock(16, 10'h2AA);
        do_lock(19, FULL);
        start_pass(1'b0, 0, '0);
        wait_done();
        read_all();

        // Lock and second start while busy are both ignored
        do_lock(19, FULL);
        start_pass(1'b0, 0, '0);
        tick();
        lock_valid = 1'b1; lock_row = RW'(5); lock_mask = FULL; start = 1'b1;
        tick();
        lock_valid = 1'b0; start = 1'b0;
        wait_done();
        repeat (3) tick();
        read_all();

        // Randomised boards, out-of-range locks, lock in the start cycle
        for (int it = 0; it < 12; it++) begin
            for (int r = 0; r < H; r++) begin
                if (r >= SP && $urandom_range(0, 3) == 0) do_lock(r, FULL);
                else if (r >= SP) do_lock(r, W'($urandom_range(0, (1 << W) - 1)));
                else if ($urandom_range(0, 5) == 0) do_lock(r, W'(1 << $urandom_range(0, W - 1)));
            end
            do_lock($urandom_range(H, (1 << RW) - 1), FULL);
            if ($urandom_range(0, 1) == 1)
                start_pass(1'b1, $urandom_range(SP, H - 1), FULL);
            else
                start_pass(1'b0, 0, '0);
            wait_done();
            read_all();
        end

        // Spawn-row occupancy, then reset in the middle of a SHIFT
        do_lock(1, 10'h010);
        do_lock(19, FULL);
        start_pass(1'b0, 0, '0);
        tick();
        reset = 1'b1;
        done_q.delete();
        busy_to = cyc;
        for (int k = 0; k < H; k++) mb[k] = '0;
        m_score = 0;
        last_lines = 0;
        tick();
        tick();
        reset = 1'b0;
        push_chk(cyc, K_GO, 0);
        push_chk(cyc, K_LC, 0);
        push_chk(cyc, K_SC, 0);
        read_all();
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/line_clear_engine.md
LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 10, board columns (4..32).
REQ-002 SHALL have parameter HEIGHT, default 20, board rows (4..32); row 0 = top, row HEIGHT-1 = bottom.
REQ-003 SHALL have parameter SPAWN_ROWS, default 2, top rows checked for game over.
REQ-004 SHALL have one clock and a synchronous, active-high reset: port clk, input, 1, rising-edge clock (CLOCK_50 at top level).
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port lock_valid, input, 1, request to OR a piece mask into a row.
REQ-007 SHALL have port lock_row, input, clog2(HEIGHT), target row of lock.
REQ-008 SHALL have port lock_mask, input, WIDTH, cells to set; bit i = column i.
REQ-009 SHALL have port lock_ready, output, 1, high when locks are accepted (= ~busy).
REQ-010 SHALL have port start, input, 1, begin clear pass.
REQ-011 SHALL have port busy, output, 1, high whenever state != IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at end of pass.
REQ-013 SHALL have port lines_cleared, output, 6, rows removed in last pass.
REQ-014 SHALL have port rd_row, input, clog2(HEIGHT), render read address; rd_data, output, WIDTH, registered row contents.
REQ-015 SHALL have port game_over, output, 1, registered OR of rows 0..SPAWN_ROWS-1.
REQ-016 SHALL have port score, output, 20, accumulated score (SCORE_LINES_EN only).

Function
REQ-017 SHALL store HEIGHT x WIDTH occupancy bits internally in registers.
REQ-018 SHALL OR lock_mask into row lock_row at the clock edge when lock_valid && lock_ready; lock_row >= HEIGHT ignored; locks while busy dropped.
REQ-019 SHALL implement FSM IDLE, SCAN, SHIFT, DONE.
REQ-020 SHALL move IDLE->SCAN on start (pointer r = HEIGHT-1, lines counter = 0); start outside IDLE ignored.
REQ-021 SHALL apply a lock and accept start in the same IDLE cycle; the locked row is seen by the pass.
REQ-022 SCAN: if row r all ones -> SHIFT; else if r==0 -> DONE; else r <= r-1.
REQ-023 SHIFT (1 cycle): rows k=1..r take row k-1, row 0 cleared, counter +1 saturating at 63, -> SCAN with r unchanged.
REQ-024 DONE: done=1 for one cycle, lines_cleared updated, -> IDLE; lines_cleared holds until next DONE.
REQ-025 For start accepted in cycle t and N rows cleared, busy SHALL be high in cycles t+1..t+HEIGHT+2N+1 and done SHALL pulse in cycle t+HEIGHT+2N+1.
REQ-026 rd_data SHALL equal row rd_row one cycle after sampling, including mid-pass content; rd_row >= HEIGHT returns 0.
REQ-027 game_over SHALL update one cycle after any change to the spawn rows.

Reset
REQ-028 Reset SHALL clear all rows, FSM -> IDLE, r=HEIGHT-1, busy/done/game_over/lines_cleared/rd_data/score = 0, overriding any pass in progress.

Configuration
REQ-029 Macro SCORE_LINES_EN defined: at DONE, score += 0/40/100/300/1200 for N = 0/1/2/3/>=4, saturating at 2^20-1.
REQ-030 Macro absent: score port and accumulator absent; all other behaviour identical.

Structure
REQ-031 Package tetris_pkg SHALL hold the FSM state enum, score weights (40, 100, 300, 1200) and SCORE_W=20.
REQ-032 Sub-module score_accum (weight lookup + saturating adder) SHALL be the only child, instantiated under SCORE_LINES_EN.

Verification (WIDTH=10, HEIGHT=20, SPAWN_ROWS=2)
REQ-033 Reset, read all rows -> rd_data=0 for every row, busy=0, game_over=0, lines_cleared=0.
REQ-034 Lock row 19 mask 0x3FF, start at t -> done at t+23, lines_cleared=1, row 19=0, score=40.
REQ-035 Rows 16..19=0x3FF, row 15=0x001, start at t -> done at t+29, lines_cleared=4, row 19=0x001, rows 0..18=0, score=1200.
REQ-036 Rows 19 and 17=0x3FF, row 18=0x155, row 16=0x2AA -> row 19=0x155, row 18=0x2AA, lines_cleared=2, score=100.
REQ-037 During busy: lock row 5 mask 0x3FF and a second start -> lock_ready=0, row 5 unchanged, only one done pulse.
REQ-038 Lock row 1 mask 0x010 -> game_over=1 next cycle; reset asserted during SHIFT -> all rows 0, busy=0 next cycle, no done pulse.
